finish_collector: RTL and testbench

FINISH_COLLECTOR -- requirements
Module: finish_collector

---
 rtl/team12_collect_pkg.sv | 24 ++
 rtl/result_fifo.sv | 47 ++++
 rtl/finish_collector.sv | 143 ++++++++++++++
 tb/tb_finish_collector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team12_collect_pkg.sv
// Shared definitions for the finish collector: default geometry, the
// unit-index width helper and the packed result-FIFO entry.
package team12_collect_pkg;

  localparam int DEF_N     = 13;
  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 4;

  // Width of a unit index; a single-unit system still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ENTRY_ID_W = id_width(DEF_N);
  localparam int ENTRY_DW   = DEF_DW;

  // One queued completion: which unit finished and what it produced.
  // Fields are sized for the default geometry.
  typedef struct packed {
    logic [ENTRY_ID_W-1:0] id;
    logic [ENTRY_DW-1:0]   data;
  } fifo_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding completed results.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs. The head entry is read combinationally.
// Storage is not reset; only the pointers are.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Pointer advance; the caller only pushes when space exists (or a pop
  // frees it in the same cycle) and only pops a valid head.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/finish_collector.sv
// Collects completion requests from N worker units, grants one per cycle
// in round-robin order, queues {unit id, result} in a small FIFO and
// tracks which units are idle for the start arbiter.
// Optional statistics: define FINISH_COLLECTOR_STATS_EN to add the
// saturating done_count output.
module finish_collector
  import team12_collect_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 MHz10,
  input  logic                 nrst,
  input  logic                 en,
  input  logic [N-1:0]         start_in,
  input  logic [N-1:0]         done_req,
  input  logic [N*DW-1:0]      done_data,
  output logic [N-1:0]         done_ack,
  output logic [N-1:0]         avail,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_id,
  output logic [DW-1:0]        out_data,
  output logic                 spurious
`ifdef FINISH_COLLECTOR_STATS_EN
  ,
  output logic [15:0]          done_count
`endif
);

  localparam int ID_W = $clog2(N);

  logic [N-1:0]    busy;
  logic [ID_W-1:0] last_grant;
  logic [N-1:0]    candidates;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic            grant_fire;
  logic            pop_fire;
  logic            fifo_full;
  logic            fifo_empty;
  fifo_entry_t     push_entry;
  fifo_entry_t     head_entry;
  logic [DW-1:0]   unit_data [N];

  // Split the flat result bus into one word per unit.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unit_data
      assign unit_data[gi] = done_data[gi*DW +: DW];
    end
  endgenerate

  // Only busy units may complete; a request from an idle unit is spurious.
  assign candidates = done_req & busy;
  assign avail      = ~busy;

  // Round-robin search starting just after the last granted unit.
  always_comb begin
    logic [ID_W:0] slot;
    grant_valid = 1'b0;
    grant_idx   = '0;
    slot        = '0;
    for (int k = 1; k <= N; k++) begin
      slot = {1'b0, last_grant} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(N)) slot = slot - (ID_W+1)'(N);
      if (!grant_valid && candidates[slot[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = slot[ID_W-1:0];
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign out_valid  = en & ~fifo_empty;
  assign pop_fire   = out_valid & out_ready;
  assign grant_fire = grant_valid & en & (~fifo_full | pop_fire);
  assign done_ack   = grant_fire ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // Build the entry pushed for the granted unit.
  always_comb begin
    push_entry      = '0;
    push_entry.id   = ENTRY_ID_W'(grant_idx);
    push_entry.data = ENTRY_DW'(unit_data[grant_idx]);
  end

  // Head fields read as zero whenever there is nothing valid to show.
  assign out_id   = out_valid ? ID_W'(head_entry.id) : '0;
  assign out_data = out_valid ? DW'(head_entry.data) : '0;

  // Busy tracking: a grant clears its unit, a start sets it; start wins.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      busy <= '0;
    end else if (en) begin
      busy <= (busy & ~done_ack) | start_in;
    end
  end

  // Round-robin pointer; reset to N-1 so unit 0 is searched first.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      last_grant <= ID_W'(N-1);
    end else if (grant_fire) begin
      last_grant <= grant_idx;
    end
  end

  // Sticky error: request from an idle unit, or start colliding with a grant.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      spurious <= 1'b0;
    end else if (en && ((|(done_req & ~busy)) || (|(start_in & done_ack)))) begin
      spurious <= 1'b1;
    end
  end

`ifdef FINISH_COLLECTOR_STATS_EN
  // Saturating count of granted completions.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      done_count <= '0;
    end else if (grant_fire && (done_count != 16'hFFFF)) begin
      done_count <= done_count + 16'd1;
    end
  end
`endif

  result_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_result_fifo (
    .clk       (MHz10),
    .nrst      (nrst),
    .push      (grant_fire),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_finish_collector.sv
// Scoreboard bench for finish_collector: expected {id, data} entries are
// queued when a grant is predicted and compared when the head is popped.
`timescale 1ns/1ps
module tb_finish_collector;

  localparam int N     = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic              MHz10 = 1'b0;
  logic              nrst = 1'b1;
  logic              en = 1'b0;
  logic              out_ready = 1'b0;
  logic [N-1:0]      start_in = '0;
  logic [N-1:0]      done_req = '0;
  logic [N*DW-1:0]   done_data = '0;
  logic [N-1:0]      done_ack;
  logic [N-1:0]      avail;
  logic              out_valid;
  logic [ID_W-1:0]   out_id;
  logic [DW-1:0]     out_data;
  logic              spurious;
`ifdef FINISH_COLLECTOR_STATS_EN
  logic [15:0]       done_count;
`endif

  int checks = 0;
  int errors = 0;
  int grants = 0;
  logic [ID_W+DW-1:0] exp_q[$];
  int rr_order[3] = '{9, 1, 5};
  logic [DW-1:0] rr_data[3] = '{16'h9999, 16'h1111, 16'h5555};

  always #5 MHz10 = ~MHz10;

  finish_collector #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .MHz10     (MHz10),
    .nrst      (nrst),
    .en        (en),
    .start_in  (start_in),
    .done_req  (done_req),
    .done_data (done_data),
    .done_ack  (done_ack),
    .avail     (avail),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .spurious  (spurious)
`ifdef FINISH_COLLECTOR_STATS_EN
    ,
    .done_count(done_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge MHz10);
    #1;
  endtask

  task automatic expect_grant(input int u, input logic [DW-1:0] d);
    exp_q.push_back({ID_W'(u), d});
    grants++;
  endtask

  task automatic launch(input int u);
    start_in = N'(1) << u;
    tick();
    start_in = '0;
  endtask

  task automatic complete(input int u, input logic [DW-1:0] d);
    done_req[u] = 1'b1;
    done_data[u*DW +: DW] = d;
    #1;
    check($sformatf("ack_u%0d", u), done_ack, N'(1) << u);
    expect_grant(u, d);
    tick();
    done_req[u] = 1'b0;
  endtask

  // Scoreboard: every accepted head entry must match the oldest prediction.
  always @(negedge MHz10) begin : monitor
    logic [ID_W+DW-1:0] e;
    if (nrst && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pop_id", out_id, e[ID_W+DW-1:DW]);
        check("pop_data", out_data, e[DW-1:0]);
        $display("pop: id=%0d data=%h", out_id, out_data);
      end
    end
  end

  initial begin
    // Reset state
    #2 nrst = 1'b0;
    tick();
    tick();
    check("rst_avail", avail, 13'h1FFF);
    check("rst_out_valid", out_valid, 0);
    check("rst_done_ack", done_ack, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_data", out_data, 0);
    check("rst_spurious", spurious, 0);
`ifdef FINISH_COLLECTOR_STATS_EN
    check("rst_done_count", done_count, 0);
`endif
    nrst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single unit round trip
    launch(2);
    check("avail_busy2", avail, 13'h1FFB);
    done_req[2] = 1'b1;
    done_data[2*DW +: DW] = 16'hBEEF;
    #1;
    check("single_ack", done_ack, 13'h0004);
    expect_grant(2, 16'hBEEF);
    tick();
    done_req[2] = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_id", out_id, 2);
    check("single_data", out_data, 16'hBEEF);
    check("single_avail", avail, 13'h1FFF);
    tick();
    check("single_drained", out_valid, 0);

    // Round-robin: move last_grant to 5, then 1/5/9 all request
    launch(5);
    complete(5, 16'h0505);
    launch(1);
    launch(5);
    launch(9);
    check("rr_avail", avail, 13'h1DDD);
    for (int i = 0; i < 3; i++) begin
      done_req[rr_order[i]] = 1'b1;
      done_data[rr_order[i]*DW +: DW] = rr_data[i];
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rr_ack%0d", i), done_ack, N'(1) << rr_order[i]);
      expect_grant(rr_order[i], rr_data[i]);
      tick();
      done_req[rr_order[i]] = 1'b0;
    end
    tick();
    tick();
    check("rr_drained", out_valid, 0);

    // FIFO full blocks the grant until a pop coincides
    out_ready = 1'b0;
    launch(4);  complete(4, 16'h4444);
    launch(6);  complete(6, 16'h6666);
    launch(8);  complete(8, 16'h8888);
    launch(10); complete(10, 16'hAAAA);
    launch(3);
    done_req[3] = 1'b1;
    done_data[3*DW +: DW] = 16'h3333;
    #1;
    check("full_no_ack", done_ack, 0);
    check("full_valid", out_valid, 1);
    tick();
    check("full_no_ack2", done_ack, 0);
    out_ready = 1'b1;
    #1;
    check("full_pop_ack", done_ack, 13'h0008);
    expect_grant(3, 16'h3333);
    tick();
    done_req[3] = 1'b0;
    repeat (6) tick();
    check("full_drained", out_valid, 0);
    check("full_queue_empty", exp_q.size(), 0);

    // Spurious request from an idle unit
    check("spur_before", spurious, 0);
    done_req[7] = 1'b1;
    #1;
    check("spur_no_ack", done_ack, 0);
    tick();
    done_req[7] = 1'b0;
    check("spur_set", spurious, 1);
    check("spur_no_push", out_valid, 0);
    tick();
    check("spur_sticky", spurious, 1);

    // Enable low freezes everything, then resumes in round-robin order
    out_ready = 1'b0;
    launch(2);
    launch(0);
    launch(11);
    complete(2, 16'h2222);
    done_req[0] = 1'b1;
    done_req[11] = 1'b1;
    done_data[0 +: DW] = 16'h0C0C;
    done_data[11*DW +: DW] = 16'hB0B0;
    en = 1'b0;
    #1;
    check("en0_ack", done_ack, 0);
    check("en0_valid", out_valid, 0);
    tick();
    start_in = 13'h0020;
    tick();
    start_in = '0;
    check("en0_avail", avail, 13'h17FE);
    check("en0_ack2", done_ack, 0);
    check("en0_valid2", out_valid, 0);
    en = 1'b1;
    #1;
    check("en1_valid", out_valid, 1);
    check("en1_ack11", done_ack, 13'h0800);
    expect_grant(11, 16'hB0B0);
    tick();
    done_req[11] = 1'b0;
    #1;
    check("en1_ack0", done_ack, 13'h0001);
    expect_grant(0, 16'h0C0C);
    tick();
    done_req[0] = 1'b0;
    check("en1_avail", avail, 13'h1FFF);

    // Reset mid-stream with three entries queued
`ifdef FINISH_COLLECTOR_STATS_EN
    check("stats_count", done_count, grants);
`endif
    check("mid_valid_before", out_valid, 1);
    nrst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_avail", avail, 13'h1FFF);
    check("mid_rst_ack", done_ack, 0);
    check("mid_rst_spurious", spurious, 0);
`ifdef FINISH_COLLECTOR_STATS_EN
    check("mid_rst_count", done_count, 0);
`endif
    exp_q.delete();
    grants = 0;
    tick();
    nrst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", out_valid, 0);

    // Start and grant of the same unit coincide: busy stays set
    launch(4);
    done_req[4] = 1'b1;
    done_data[4*DW +: DW] = 16'h4AAA;
    start_in = 13'h0010;
    #1;
    check("setprio_ack", done_ack, 13'h0010);
    expect_grant(4, 16'h4AAA);
    tick();
    start_in = '0;
    done_req[4] = 1'b0;
    check("setprio_avail", avail, 13'h1FEF);
    check("setprio_spurious", spurious, 1);
    complete(4, 16'h4BBB);
    check("setprio_release", avail, 13'h1FFF);
    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", out_valid, 0);
`ifdef FINISH_COLLECTOR_STATS_EN
    check("final_count", done_count, grants);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
